// File: rtl/instr_mem_fetch_port.sv
// instr_mem_fetch_port
//   Instruction-memory read port behind the program counter. It accepts one
//   fetch address per cycle under PCValid/PCReady and reads a DEPTH-word store
//   through a registered (block-RAM style) read. The read passes through a
//   READ_LATENCY-deep valid pipeline into a 2-entry in-order output FIFO.
//   A credit counter bounds in-flight plus buffered fetches to two. Because of
//   that bound, the FIFO can never overflow and the pipeline never has to stall.
//   A separate load port writes the store. Reads are read-before-write against
//   a same-cycle load.
//   Optional feature macro: IMEM_PARITY_EN. When it is defined, every stored
//   word carries an even-parity bit that is written at load and checked on read.
//   The check result travels with the data, and the ParityErr port is present.
module instr_mem_fetch_port #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] PCAddr,
  input  logic                  PCValid,
  output logic                  PCReady,
  output logic [DATA_WIDTH-1:0] InstrOut,
  output logic                  InstrValid,
  input  logic                  InstrReady,
  input  logic                  Flush,
  input  logic                  LoadEn,
  input  logic [ADDR_WIDTH-1:0] LoadAddr,
  input  logic [DATA_WIDTH-1:0] LoadData
`ifdef IMEM_PARITY_EN
  ,
  output logic                  ParityErr
`endif
);

  // Width of one stored word and of one pipeline/buffer entry.
  // With parity enabled, the extra bit is the stored parity bit in the store.
  // In the pipeline and buffer, that extra bit is the parity-error flag.
`ifdef IMEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int EW  = DATA_WIDTH + PAR_W;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] DEPTH_L = AW1'(DEPTH);

  // Instruction store. It is deliberately not reset.
  logic [EW-1:0]           r_mem [0:DEPTH-1];

  // Registered read port (pipeline stage 0).
  logic [EW-1:0]           r_rd_word;
  logic                    r_rd_oor;

  // Pipeline entry seen at the output of each stage, plus the stage valids.
  logic [EW-1:0]           w_pipe_entry [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [READ_LATENCY-1:0] w_vld_next;

  // 2-entry output FIFO.
  logic [EW-1:0]           r_buf [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;

  // Credit counter: in-flight plus buffered fetches (0..2).
  logic [1:0]              r_credit;
  logic [2:0]              w_credit_after_pop;

  // Keeps PCReady low until the first edge after reset release.
  logic                    r_ready_en;

  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_pc_in_range;
  logic                    w_load_in_range;
  logic [EW-1:0]           w_load_word;
  logic [EW-1:0]           w_head;

  assign w_pc_in_range   = ({1'b0, PCAddr}   < DEPTH_L);
  assign w_load_in_range = ({1'b0, LoadAddr} < DEPTH_L);

`ifdef IMEM_PARITY_EN
  // The parity bit makes the XOR of the whole stored word zero (even parity).
  assign w_load_word = {^LoadData, LoadData};
`else
  assign w_load_word = LoadData;
`endif

  // Handshakes. A same-cycle pop frees a credit, so an always-ready consumer
  // sees one fetch per cycle. Flush refuses the request presented with it.
  assign w_pop              = InstrValid && InstrReady;
  assign w_credit_after_pop = {1'b0, r_credit} - {2'b00, w_pop};
  assign PCReady            = r_ready_en && !Flush && (w_credit_after_pop < 3'd2);
  assign w_accept           = PCValid && PCReady;
  assign w_push             = r_pipe_vld[READ_LATENCY-1] && !Flush;

  // Store write and registered read. The nonblocking write makes a same-address
  // read return the old word (read-before-write).
  always_ff @(posedge Clk) begin
    if (LoadEn && w_load_in_range) begin
      r_mem[LoadAddr] <= w_load_word;
    end
    if (w_accept) begin
      r_rd_word <= r_mem[PCAddr];
      r_rd_oor  <= !w_pc_in_range;
    end
  end

  // Stage 0 converts the raw word into an entry. An out-of-range address
  // becomes an all-zero NOP, and the stored parity bit becomes an error flag.
`ifdef IMEM_PARITY_EN
  assign w_pipe_entry[0] = r_rd_oor ? '0 : {^r_rd_word, r_rd_word[DATA_WIDTH-1:0]};
`else
  assign w_pipe_entry[0] = r_rd_oor ? '0 : r_rd_word;
`endif

  // Extra latency stages. Only the valid bits need reset; the data simply
  // follows the valids.
  genvar gi;
  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
      logic [EW-1:0] r_stage;

      // Advance the entry one stage per cycle.
      always_ff @(posedge Clk) begin
        r_stage <= w_pipe_entry[gi-1];
      end

      assign w_pipe_entry[gi] = r_stage;
    end
  endgenerate

  // Next valid vector: an accept enters stage 0, and older fetches shift down.
  // Flush empties the pipeline.
  always_comb begin
    w_vld_next = '0;
    if (!Flush) begin
      w_vld_next[0] = w_accept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        w_vld_next[i] = r_pipe_vld[i-1];
      end
    end
  end

  // Pipeline valids, credit counter and ready enable.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pipe_vld <= '0;
      r_credit   <= 2'd0;
      r_ready_en <= 1'b0;
    end else begin
      r_pipe_vld <= w_vld_next;
      r_ready_en <= 1'b1;
      if (Flush) begin
        r_credit <= 2'd0;
      end else begin
        r_credit <= r_credit + {1'b0, w_accept} - {1'b0, w_pop};
      end
    end
  end

  // Output FIFO. Pointers wrap modulo 2, and push+pop together keep the count.
  // Flush overrides both push and pop.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (Flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= w_pipe_entry[READ_LATENCY-1];
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign w_head     = r_buf[r_rd_ptr];
  assign InstrValid = (r_count != 2'd0);
  assign InstrOut   = InstrValid ? w_head[DATA_WIDTH-1:0] : '0;

`ifdef IMEM_PARITY_EN
  assign ParityErr = InstrValid && w_head[DATA_WIDTH];
`endif

  // The credit bound is structural. Reaching 3, or drifting from the real
  // occupancy, means the handshake logic is broken.
  a_credit_bound : assert property (@(posedge Clk) disable iff (!Reset)
    r_credit <= 2'd2);
  a_credit_match : assert property (@(posedge Clk) disable iff (!Reset)
    (int'($countones(r_pipe_vld)) + int'(r_count)) == int'(r_credit));

endmodule

// File: tb/tb_instr_mem_fetch_port.sv
// Testbench for instr_mem_fetch_port.
// The reference model is a queue of outstanding fetches. Each entry carries
// the word it must return and the edge count after which it becomes visible.
// PCReady, InstrValid, InstrOut (and ParityErr with IMEM_PARITY_EN) are
// predicted from that queue every cycle.
module tb_instr_mem_fetch_port;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 24;  // below 2**AW so out-of-range NOP fetches occur
  localparam int LAT   = 1;

  logic          Clk;
  logic          Reset;
  logic [AW-1:0] PCAddr;
  logic          PCValid;
  logic          PCReady;
  logic [DW-1:0] InstrOut;
  logic          InstrValid;
  logic          InstrReady;
  logic          Flush;
  logic          LoadEn;
  logic [AW-1:0] LoadAddr;
  logic [DW-1:0] LoadData;
`ifdef IMEM_PARITY_EN
  logic          ParityErr;
`endif

  instr_mem_fetch_port #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .READ_LATENCY(LAT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .PCAddr    (PCAddr),
    .PCValid   (PCValid),
    .PCReady   (PCReady),
    .InstrOut  (InstrOut),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .Flush     (Flush),
    .LoadEn    (LoadEn),
    .LoadAddr  (LoadAddr),
    .LoadData  (LoadData)
`ifdef IMEM_PARITY_EN
    ,
    .ParityErr (ParityErr)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [DW-1:0] word;
    logic [AW-1:0] addr;
    logic          bad;
    int            avail;
  } ent_t;

  ent_t          mdl_q[$];
  logic [DW-1:0] mdl_mem [32];
  logic          mdl_bad [32];
  int            edges;
  int            n_tests;
  int            n_fail;

  // Single comparison point. Every check is counted here.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  // One clock cycle. Drive inputs after the falling edge and check the
  // predicted outputs. Then apply what happens at the rising edge to the model.
  task automatic step(input logic pv, input logic [AW-1:0] pa, input logic ir,
                      input logic fl, input logic le, input logic [AW-1:0] la,
                      input logic [DW-1:0] ld);
    logic          exp_valid;
    logic          exp_pop;
    logic          exp_ready;
    ent_t          e;
    @(negedge Clk);
    PCValid    = pv;
    PCAddr     = pa;
    InstrReady = ir;
    Flush      = fl;
    LoadEn     = le;
    LoadAddr   = la;
    LoadData   = ld;
    #1;
    exp_valid = (mdl_q.size() > 0) && (mdl_q[0].avail <= edges);
    exp_pop   = exp_valid && ir;
    exp_ready = (edges >= 1) && !fl && ((mdl_q.size() - (exp_pop ? 1 : 0)) < 2);
    chk("pc_ready", 64'(PCReady), 64'(exp_ready));
    chk("instr_valid", 64'(InstrValid), 64'(exp_valid));
    if (exp_valid) begin
      chk("instr_out", 64'(InstrOut), 64'(mdl_q[0].word));
    end
`ifdef IMEM_PARITY_EN
    chk("parity_err", 64'(ParityErr), 64'(exp_valid && mdl_q[0].bad));
`endif
    if (exp_pop) begin
      $display("[TB] edge %0d pop addr=%0d word=%h", edges, mdl_q[0].addr, mdl_q[0].word);
    end
    @(posedge Clk);
    edges++;
    if (fl) begin
      mdl_q.delete();
    end else begin
      if (exp_pop) begin
        void'(mdl_q.pop_front());
      end
      if (pv && exp_ready) begin
        e.addr  = pa;
        e.word  = (int'(pa) < DEPTH) ? mdl_mem[pa] : '0;
        e.bad   = (int'(pa) < DEPTH) ? mdl_bad[pa] : 1'b0;
        e.avail = edges + LAT;
        mdl_q.push_back(e);
      end
    end
    if (le && (int'(la) < DEPTH)) begin
      mdl_mem[la] = ld;
      mdl_bad[la] = 1'b0;
    end
  endtask

  task automatic idle(input int n, input logic ir);
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0, ir, 1'b0, 1'b0, '0, '0);
    end
  endtask

  initial begin
    logic          pv;
    logic          ir;
    logic          fl;
    logic          le;
    logic [AW-1:0] pa;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;

    n_tests    = 0;
    n_fail     = 0;
    edges      = 0;
    Reset      = 1'b0;
    PCValid    = 1'b0;
    PCAddr     = '0;
    InstrReady = 1'b0;
    Flush      = 1'b0;
    LoadEn     = 1'b0;
    LoadAddr   = '0;
    LoadData   = '0;
    for (int i = 0; i < 32; i++) begin
      mdl_mem[i] = '0;
      mdl_bad[i] = 1'b0;
    end

    // Reset held low for three cycles.
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_instr_valid", 64'(InstrValid), 64'd0);
    chk("rst_instr_out", 64'(InstrOut), 64'd0);
    chk("rst_pc_ready", 64'(PCReady), 64'd0);
    Reset = 1'b1;
    #1;
    chk("rel_pc_ready", 64'(PCReady), 64'd0);
    @(posedge Clk);
    edges = 1;

    // Fill every in-range word so that no fetch reads an unwritten location.
    for (int a = 0; a < 32; a++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, AW'(a), $urandom);
    end

    // Single fetch with the minimum request-to-valid latency.
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h2000_0001);
    step(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(3, 1'b1);

    // Stream addresses 0..7 to a consumer that is always ready.
    for (int a = 0; a < 8; a++) begin
      step(1'b1, AW'(a), 1'b1, 1'b0, 1'b0, '0, '0);
    end
    idle(3, 1'b1);

    // Back-pressure: two accepts fill the credits, then drain.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, AW'(10 + i), 1'b0, 1'b0, 1'b0, '0, '0);
    end
    step(1'b1, 5'd20, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(4, 1'b1);

    // Flush with two fetches outstanding. A load issued in the same cycle still lands.
    step(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 32'hCAFE_0004);
    idle(2, 1'b1);
    step(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(2, 1'b1);

    // A fetch and a load to the same address in one cycle, then an out-of-range fetch.
    step(1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 32'h1234_5678);
    step(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 5'd30, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(3, 1'b1);

`ifdef IMEM_PARITY_EN
    // Corrupt one stored bit at address 5 behind the load port.
    @(negedge Clk);
    dut.r_mem[5][0] = ~dut.r_mem[5][0];
    mdl_bad[5] = 1'b1;
    step(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(3, 1'b1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      pv = ($urandom_range(0, 3) != 0);
      pa = AW'($urandom_range(0, 31));
      ir = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 19) == 0);
      le = ($urandom_range(0, 3) == 0);
      la = AW'($urandom_range(0, 31));
      ld = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        la = pa;
      end
      step(pv, pa, ir, fl, le, la, ld);
    end
    idle(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
